key_event_capture: RTL and testbench

//  Downstream consumer of the 8-to-3 active-low priority encoder on the key/switch input path.
//  - Synchronises the encoder outputs (A, GS) and debounces them.
//  - Converts each debounced key press into one key-index event.
//  - Buffers events in a small FIFO and hands them to the control logic over a valid/ready handshake.

---
 rtl/key_event_capture.sv | 169 ++++++++++++++++
 tb/tb_key_event_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_capture.sv
// Debounces the active-low 8:3 priority encoder outputs, turns each accepted key press into a
// single key-index event, and queues the events in a small first-word-fall-through FIFO.
module key_event_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       enc_a,
    input  logic             enc_gs,
    output logic [2:0]       key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic [CNT_W-1:0] key_count,
    output logic             overflow
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPressDb, StPressed, StRelDb} state_e;

    // Synchroniser; resets to the inactive (all-ones) encoder code
    logic [3:0] sync1_q, sync2_q;
    logic       s_act;
    logic [2:0] s_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {enc_gs, enc_a};
            sync2_q <= sync1_q;
        end
    end

    assign s_act = ~sync2_q[3];
    assign s_idx = ~sync2_q[2:0];

    state_e         state_q, state_d;
    logic [DbW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]     cand_q, cand_d, cur_q, cur_d;
    logic           push;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DbW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        cur_d   = cur_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_act) begin
                    cand_d  = s_idx;
                    cnt_d   = DbW'(1);
                    state_d = StPressDb;
                end
            end
            StPressDb: begin
                if (!s_act) begin
                    state_d = StIdle;
                end else if (s_idx != cand_q) begin
                    cand_d = s_idx;
                    cnt_d  = DbW'(1);
                end else if (cnt_q == DbLast) begin
                    push    = 1'b1;
                    cur_d   = cand_q;
                    state_d = StPressed;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPressed: begin
                if (!s_act) begin
                    cnt_d   = DbW'(1);
                    state_d = StRelDb;
                end else if (s_idx != cur_q) begin
                    cand_d  = s_idx;
                    cnt_d   = DbW'(1);
                    state_d = StPressDb;
                end
            end
            StRelDb: begin
                // A short release bounce back to the same key resumes the hold silently
                if (s_act && s_idx == cur_q) begin
                    state_d = StPressed;
                end else if (s_act) begin
                    cand_d  = s_idx;
                    cnt_d   = DbW'(1);
                    state_d = StPressDb;
                end else if (cnt_q == DbLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            cur_q   <= cur_d;
        end
    end

    assign key_held = (state_q == StPressed) || (state_q == StRelDb);

    logic [2:0]       mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full, pop, do_push;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = key_valid & key_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign key_valid = (count_q != '0);
    assign key_code  = key_valid ? mem[rptr_q] : 3'd0;
    assign key_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_capture.sv
// Bench for key_event_capture: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_key_event_capture;

    localparam int unsigned DB    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    enc_a;
    logic          enc_gs;
    logic [2:0]    key_code;
    logic          key_valid;
    logic          key_ready;
    logic          key_held;
    logic [CW-1:0] key_count;
    logic          overflow;

    key_event_capture #(
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH     (DEPTH),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enc_a    (enc_a),
        .enc_gs   (enc_gs),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .key_count(key_count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: delay line for the synchroniser, phase/count per the debounce rules,
    // and a plain queue for the event FIFO.
    localparam int PIdle = 0, PPressDb = 1, PPressed = 2, PRelDb = 3;
    logic [3:0] m_s1, m_s2;
    int         m_phase, m_cnt;
    logic [2:0] m_cand, m_cur, m_ev;
    logic [2:0] m_q[$];
    logic       m_ovf;
    bit         armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 4'hf; m_s2 = 4'hf;
            m_phase = PIdle; m_cnt = 0; m_cand = 0; m_cur = 0;
            m_q.delete(); m_ovf = 0;
            armed = 1;
        end else begin
            bit         act, ev;
            logic [2:0] idx;
            act = !m_s2[3];
            idx = ~m_s2[2:0];
            ev  = 0;
            m_ev = m_cand;
            case (m_phase)
                PIdle: if (act) begin m_cand = idx; m_cnt = 1; m_phase = PPressDb; end
                PPressDb:
                    if (!act) m_phase = PIdle;
                    else if (idx != m_cand) begin m_cand = idx; m_cnt = 1; end
                    else if (m_cnt == DB - 1) begin ev = 1; m_cur = m_cand; m_phase = PPressed; end
                    else m_cnt++;
                PPressed:
                    if (!act) begin m_cnt = 1; m_phase = PRelDb; end
                    else if (idx != m_cur) begin m_cand = idx; m_cnt = 1; m_phase = PPressDb; end
                PRelDb:
                    if (act && idx == m_cur) m_phase = PPressed;
                    else if (act) begin m_cand = idx; m_cnt = 1; m_phase = PPressDb; end
                    else if (m_cnt == DB - 1) m_phase = PIdle;
                    else m_cnt++;
                default: m_phase = PIdle;
            endcase
            if (key_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ev);
                else m_ovf = 1;
            end
            m_s2 = m_s1;
            m_s1 = {enc_gs, enc_a};
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", int'(key_valid), int'(m_q.size() > 0));
            chk("count", int'(key_count), m_q.size());
            chk("code", int'(key_code), (m_q.size() > 0) ? int'(m_q[0]) : 0);
            chk("held", int'(key_held), int'(m_phase == PPressed || m_phase == PRelDb));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] idx);
        enc_gs = 1'b0; enc_a = ~idx;
        tick(8);
        enc_gs = 1'b1; enc_a = 3'b111;
        tick(8);
    endtask

    task automatic pop_one(input int exp_code, input string name);
        chk(name, int'(key_code), exp_code);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enc_gs = 1'b1; enc_a = 3'b111; key_ready = 1'b0;
        tick(3);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_count", int'(key_count), 0);
        rst = 1'b0;
        tick(2);

        // Clean press of index 5: event appears after edge k+DB+1
        enc_gs = 1'b0; enc_a = 3'b010;
        tick(5);
        chk("press_early_valid", int'(key_valid), 0);
        tick(1);
        chk("press_valid", int'(key_valid), 1);
        chk("press_code", int'(key_code), 5);
        chk("press_count", int'(key_count), 1);
        chk("press_held", int'(key_held), 1);
        tick(4);
        chk("hold_no_repeat", int'(key_count), 1);
        enc_gs = 1'b1; enc_a = 3'b111;
        tick(8);
        press(3'd3);
        chk("two_entries", int'(key_count), 2);

        // Reset mid-debounce with two entries queued
        enc_gs = 1'b0; enc_a = ~3'd7;
        tick(3);
        rst = 1'b1; enc_gs = 1'b1; enc_a = 3'b111;
        tick(1);
        chk("midrst_valid", int'(key_valid), 0);
        chk("midrst_count", int'(key_count), 0);
        chk("midrst_code", int'(key_code), 0);
        chk("midrst_held", int'(key_held), 0);
        tick(1);
        rst = 1'b0;
        tick(10);
        chk("postrst_count", int'(key_count), 0);

        // Press bounce shorter than the debounce window
        enc_a = 3'b100;
        repeat (5) begin
            enc_gs = 1'b0; tick(2);
            enc_gs = 1'b1; tick(2);
        end
        tick(10);
        chk("bounce_count", int'(key_count), 0);
        chk("bounce_held", int'(key_held), 0);

        // Short release bounce on a held key yields no second event
        enc_gs = 1'b0; enc_a = ~3'd4;
        tick(8);
        enc_gs = 1'b1; tick(2);
        enc_gs = 1'b0; tick(10);
        chk("relbounce_count", int'(key_count), 1);
        chk("relbounce_held", int'(key_held), 1);
        pop_one(4, "relbounce_code");
        enc_gs = 1'b1; enc_a = 3'b111;
        tick(8);

        // Key change while held: 2 then 6
        enc_gs = 1'b0; enc_a = ~3'd2;
        tick(8);
        chk("chg_first", int'(key_code), 2);
        enc_a = ~3'd6;
        tick(5);
        chk("chg_early", int'(key_count), 1);
        tick(1);
        chk("chg_count", int'(key_count), 2);
        pop_one(2, "chg_order0");
        pop_one(6, "chg_order1");
        key_ready = 1'b1;
        tick(3);
        key_ready = 1'b0;
        chk("pop_empty", int'(key_count), 0);
        enc_gs = 1'b1; enc_a = 3'b111;
        tick(8);

        // Overflow: five presses into a four-entry FIFO
        for (int i = 1; i <= 5; i++) press(3'(i));
        chk("ovf_count", int'(key_count), 4);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 1; i <= 4; i++) pop_one(i, "ovf_order");
        chk("ovf_sticky", int'(overflow), 1);
        rst = 1'b1; tick(2); rst = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // Full FIFO, push coincides with a pop
        for (int i = 0; i <= 3; i++) press(3'(i));
        chk("full_count", int'(key_count), 4);
        enc_gs = 1'b0; enc_a = ~3'd7;
        tick(5);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        chk("pp_count", int'(key_count), 4);
        chk("pp_overflow", int'(overflow), 0);
        pop_one(1, "pp_order0");
        pop_one(2, "pp_order1");
        pop_one(3, "pp_order2");
        pop_one(7, "pp_order3");
        enc_gs = 1'b1; enc_a = 3'b111;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
